// File: rtl/ex_mdu_pkg.sv
// Shared opcodes, result classes and divider state encodings for the execute stage.
package ex_mdu_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [2:0] {
    EXE_RES_NOP   = 3'b000,
    EXE_RES_LOGIC = 3'b001,
    EXE_RES_SHIFT = 3'b010,
    EXE_RES_MOVE  = 3'b011,
    EXE_RES_ARITH = 3'b100
  } alusel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIV_ON  = 2'b01,
    DIV_END = 2'b10
  } div_state_e;

endpackage

// File: rtl/ex_mdu_if.sv
// Issue/result bundle between ID/EX, the execute stage and EX/MEM.
interface ex_mdu_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  valid_i;
  logic                  ready_o;
  logic [7:0]            aluop_i;
  logic [2:0]            alusel_i;
  logic [DATA_W-1:0]     reg1_i;
  logic [DATA_W-1:0]     reg2_i;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i;
  logic                  valid_o;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [DATA_W-1:0]     wdata_o;

  modport master (
    output valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  ready_o, valid_o, wd_o, wreg_o, wdata_o
  );

  modport slave (
    input  valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output ready_o, valid_o, wd_o, wreg_o, wdata_o
  );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, signs applied in DIV_END.
module ex_div
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_quo, r_rem, r_dvs;
  logic              r_q_neg, r_r_neg;
  logic [DATA_W-1:0] w_a_mag, w_b_mag;
  logic [DATA_W:0]   w_part, w_diff;
  logic              w_step_last;

  assign w_a_mag     = (signed_div && dividend[DATA_W-1]) ? -dividend : dividend;
  assign w_b_mag     = (signed_div && divisor[DATA_W-1])  ? -divisor  : divisor;
  assign w_part      = {r_rem, r_quo[DATA_W-1]};
  assign w_diff      = w_part - {1'b0, r_dvs};
  assign w_step_last = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start && !abort) w_state_nxt = (divisor == '0) ? DIV_END : DIV_ON;
      DIV_ON:  if (abort) w_state_nxt = IDLE;
               else if (w_step_last) w_state_nxt = DIV_END;
      DIV_END: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_cnt <= '0;
      r_dvs <= w_b_mag;
      // Divide-by-zero skips the iterations and bypasses sign correction.
      if (divisor == '0) begin
        r_quo   <= '1;
        r_rem   <= dividend;
        r_q_neg <= 1'b0;
        r_r_neg <= 1'b0;
      end else begin
        r_quo   <= w_a_mag;
        r_rem   <= '0;
        r_q_neg <= signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
        r_r_neg <= signed_div & dividend[DATA_W-1];
      end
    end else if (r_state == DIV_ON) begin
      r_cnt <= r_cnt + 1'b1;
      if (!w_diff[DATA_W]) begin
        r_rem <= w_diff[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
      end else begin
        r_rem <= w_part[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DIV_END);
  assign quotient  = r_q_neg ? -r_quo : r_quo;
  assign remainder = r_r_neg ? -r_rem : r_rem;
endmodule

// File: rtl/ex_mdu.sv
// Execute stage: logic/shift/arith/move, single-cycle multiply, iterative divide, HI/LO.
// EX_OVF_TRAP_EN: ADD/SUB signed overflow raises ovf_o and suppresses the register write.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  ex_mdu_if.slave           bus,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stall_req_o,
  output logic              ovf_o
);
  logic [7:0]            w_op;
  logic [DATA_W-1:0]     w_a, w_b, w_sum, w_diff, w_q, w_r;
  logic [DATA_W-1:0]     w_logic, w_shift, w_arith, w_move, w_result;
  logic [2*DATA_W-1:0]   w_prod;
  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_accept, w_is_div, w_is_mul, w_no_wb, w_ovf;
  logic                  w_div_busy, w_div_done;

  logic                  r_valid, r_wreg, r_ovf;
  logic [REG_ADDR_W-1:0] r_wd;
  logic [DATA_W-1:0]     r_wdata, r_hi, r_lo;

  assign w_op     = bus.aluop_i;
  assign w_a      = bus.reg1_i;
  assign w_b      = bus.reg2_i;
  assign w_shamt  = w_a[SHAMT_W-1:0];
  assign w_sum    = w_a + w_b;
  assign w_diff   = w_a - w_b;
  assign w_is_div = (w_op == EXE_DIV_OP) || (w_op == EXE_DIVU_OP);
  assign w_is_mul = (w_op == EXE_MULT_OP) || (w_op == EXE_MULTU_OP);
  assign w_no_wb  = w_is_mul || (w_op == EXE_MTHI_OP) || (w_op == EXE_MTLO_OP);
  assign w_accept = bus.valid_i & ~w_div_busy & ~flush_i;

`ifdef EX_OVF_TRAP_EN
  assign w_ovf = ((w_op == EXE_ADD_OP) && (w_a[DATA_W-1] == w_b[DATA_W-1]) &&
                  (w_sum[DATA_W-1] != w_a[DATA_W-1])) ||
                 ((w_op == EXE_SUB_OP) && (w_a[DATA_W-1] != w_b[DATA_W-1]) &&
                  (w_diff[DATA_W-1] != w_a[DATA_W-1]));
`else
  assign w_ovf = 1'b0;
`endif

  always_comb begin
    if (w_op == EXE_MULT_OP)
      w_prod = {{DATA_W{w_a[DATA_W-1]}}, w_a} * {{DATA_W{w_b[DATA_W-1]}}, w_b};
    else
      w_prod = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};
  end

  always_comb begin
    w_logic = '0;
    w_shift = '0;
    w_arith = '0;
    w_move  = '0;
    case (w_op)
      EXE_OR_OP:   w_logic = w_a | w_b;
      EXE_AND_OP:  w_logic = w_a & w_b;
      EXE_XOR_OP:  w_logic = w_a ^ w_b;
      EXE_NOR_OP:  w_logic = ~(w_a | w_b);
      EXE_SLL_OP:  w_shift = w_b << w_shamt;
      EXE_SRL_OP:  w_shift = w_b >> w_shamt;
      EXE_SRA_OP:  w_shift = $signed(w_b) >>> w_shamt;
      EXE_ADD_OP, EXE_ADDU_OP: w_arith = w_sum;
      EXE_SUB_OP, EXE_SUBU_OP: w_arith = w_diff;
      EXE_SLT_OP:  w_arith = {{(DATA_W-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      EXE_SLTU_OP: w_arith = {{(DATA_W-1){1'b0}}, w_a < w_b};
      EXE_MFHI_OP: w_move  = r_hi;
      EXE_MFLO_OP: w_move  = r_lo;
      default: ;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (bus.alusel_i)
      EXE_RES_LOGIC: w_result = w_logic;
      EXE_RES_SHIFT: w_result = w_shift;
      EXE_RES_ARITH: w_result = w_arith;
      EXE_RES_MOVE:  w_result = w_move;
      default: ;
    endcase
  end

  ex_div #(.DATA_W(DATA_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (w_accept & w_is_div),
    .signed_div (w_op == EXE_DIV_OP),
    .dividend   (w_a),
    .divisor    (w_b),
    .abort      (flush_i),
    .busy       (w_div_busy),
    .done       (w_div_done),
    .quotient   (w_q),
    .remainder  (w_r)
  );

  // HI/LO land on the accept edge, so a following MFHI/MFLO sees them without a bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wreg  <= 1'b0;
      r_ovf   <= 1'b0;
      r_wd    <= '0;
      r_wdata <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      if (w_accept) begin
        r_wd <= bus.wd_i;
        if (!w_is_div) begin
          r_valid <= 1'b1;
          r_wdata <= w_result;
          r_wreg  <= bus.wreg_i & ~w_no_wb & ~w_ovf;
          r_ovf   <= w_ovf;
          if (w_is_mul) begin
            r_hi <= w_prod[2*DATA_W-1:DATA_W];
            r_lo <= w_prod[DATA_W-1:0];
          end
          if (w_op == EXE_MTHI_OP) r_hi <= w_a;
          if (w_op == EXE_MTLO_OP) r_lo <= w_a;
        end
      end else if (w_div_done && !flush_i) begin
        r_valid <= 1'b1;
        r_wreg  <= 1'b0;
        r_wdata <= '0;
        r_hi    <= w_r;
        r_lo    <= w_q;
      end
    end
  end

  assign bus.ready_o = ~w_div_busy;
  assign bus.valid_o = r_valid;
  assign bus.wd_o    = r_wd;
  assign bus.wreg_o  = r_wreg;
  assign bus.wdata_o = r_wdata;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;
  assign stall_req_o = w_div_busy;
  assign ovf_o       = r_ovf;
endmodule
